// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state encoding and request legality helper for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_STORE  = 3'd2;
    localparam logic [2:0] ST_RMW_RD = 3'd3;
    localparam logic [2:0] ST_RMW_WR = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD   = ST_LOAD,
        STORE  = ST_STORE,
        RMW_RD = ST_RMW_RD,
        RMW_WR = ST_RMW_WR,
        RESP   = ST_RESP
    } lsu_state_e;

    // Stores only have the signed-looking encodings; unsigned variants exist for loads only.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and word-memory signals of the load/store unit.
interface lsu_if #(parameter int ADDR_W = 32);

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic              req_is_store;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_funct3, req_is_store, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_addr, mem_wdata, mem_read_en, mem_write_en,
        input  mem_rdata
    );

    modport slave (
        output req_valid, req_funct3, req_is_store, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_addr, mem_wdata, mem_read_en, mem_write_en,
        output mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: sub-word load extraction/extension and store read-modify-write merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = word_i[{addr_lo_i, 3'b000} +: 8];
        lane_half = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        load_data_o = word_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_data_o = {24'h0, lane_byte};
            F3_H:    load_data_o = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_data_o = {16'h0, lane_half};
            default: load_data_o = word_i;
        endcase

        merged_o = word_i;
        case (funct3_i[1:0])
            2'b00: merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            2'b01: begin
                if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
                else              merged_o[15:0]  = wdata_i[15:0];
            end
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store initiator onto a word-only memory port.
// Sub-word stores are done as read-modify-write; bad requests respond with an error and never touch memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 28,
    parameter int ADDR_W    = 32
) (
    input  logic clk,
    input  logic reset,
    lsu_if.master bus
);

    lsu_state_e        state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       merged_q, merged_d;
    logic              err_q, err_d;

    logic [31:0] load_ext;
    logic [31:0] store_merged;
    logic        misaligned;
    logic        out_of_range;
    logic        req_bad;

    lsu_align u_align (
        .word_i      (bus.mem_rdata),
        .addr_lo_i   (addr_q[1:0]),
        .funct3_i    (f3_q),
        .wdata_i     (wdata_q),
        .load_data_o (load_ext),
        .merged_o    (store_merged)
    );

    always_comb begin
        misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        out_of_range = bus.req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_WORDS);
        req_bad      = misaligned || out_of_range || !f3_legal(bus.req_funct3, bus.req_is_store);
    end

    always_comb begin
        state_d  = state_q;
        f3_d     = f3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        merged_d = merged_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = 32'h0;
                    err_d   = req_bad;
                    if (req_bad)                      state_d = RESP;
                    else if (!bus.req_is_store)       state_d = LOAD;
                    else if (bus.req_funct3 == F3_W)  state_d = STORE;
                    else                              state_d = RMW_RD;
                end
            end
            LOAD: begin
                rdata_d = load_ext;
                state_d = RESP;
            end
            STORE:  state_d = RESP;
            RMW_RD: begin
                merged_d = store_merged;
                state_d  = RMW_WR;
            end
            RMW_WR: state_d = RESP;
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            f3_q     <= 3'h0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            merged_q <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            merged_q <= merged_d;
            err_q    <= err_d;
        end
    end

    // Outputs decode purely from state and registers, so nothing toggles on request inputs.
    assign bus.req_ready    = (state_q == IDLE);
    assign bus.resp_valid   = (state_q == RESP);
    assign bus.resp_rdata   = rdata_q;
    assign bus.resp_err     = err_q;
    assign bus.mem_read_en  = (state_q == LOAD)  || (state_q == RMW_RD);
    assign bus.mem_write_en = (state_q == STORE) || (state_q == RMW_WR);
    assign bus.mem_addr     = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata    = (state_q == STORE)  ? wdata_q :
                              (state_q == RMW_WR) ? merged_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 28-word memory that gives reset priority over write.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.MEM_WORDS(28), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:27];
    wire  [29:0] widx = bus.mem_addr[31:2];

    assign bus.mem_rdata = (bus.mem_read_en && widx < 30'd28) ? mem[widx[4:0]] : 32'h0;

    always @(posedge clk)
        if (!reset && bus.mem_write_en && widx < 30'd28) mem[widx[4:0]] <= bus.mem_wdata;

    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [31:0] last_wr_addr = 32'h0;
    always @(negedge clk) begin
        if (bus.mem_read_en) rd_cnt++;
        if (bus.mem_write_en) begin
            wr_cnt++;
            last_wr_addr = bus.mem_addr;
        end
        if (bus.mem_read_en && bus.mem_write_en) both_cnt++;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request, waits (bounded) for the response, then accepts it.
    task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic e,
                       output int drd, output int dwr);
        int rd0, wr0;
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus.resp_rdata;
        e  = bus.resp_err;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        drd = rd_cnt - rd0;
        dwr = wr_cnt - wr0;
    endtask

    int          lat, drd, dwr;
    logic [31:0] rd;
    logic        e;

    logic [31:0] ld_addr [5] = '{32'h0C, 32'h0F, 32'h0F, 32'h0E, 32'h0E};
    logic [2:0]  ld_f3   [5] = '{F3_B, F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] ld_exp  [5] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};

    logic        er_st   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  er_f3   [4] = '{F3_W, F3_H, F3_W, 3'b011};
    logic [31:0] er_addr [4] = '{32'h02, 32'h03, 32'h70, 32'h00};

    initial begin
        int rd0, wr0;
        for (int i = 0; i < 28; i++) mem[i] = 32'h0;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'h0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.resp_ready   = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_rd_en", {31'h0, bus.mem_read_en}, 32'h0);
        chk("rst_wr_en", {31'h0, bus.mem_write_en}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);

        txn(1'b1, F3_W, 32'h08, 32'hDEADBEEF, lat, rd, e, drd, dwr);
        chk("sw_lat", lat, 2);
        chk("sw_err", {31'h0, e}, 32'h0);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_wr_cycles", dwr, 1);
        chk("sw_rd_cycles", drd, 0);
        chk("sw_wr_addr", last_wr_addr, 32'h08);
        chk("sw_mem", mem[2], 32'hDEADBEEF);

        txn(1'b0, F3_W, 32'h08, 32'h0, lat, rd, e, drd, dwr);
        chk("lw_lat", lat, 2);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", {31'h0, e}, 32'h0);
        chk("lw_rd_cycles", drd, 1);

        mem[3] = 32'h80FF7F01;
        for (int i = 0; i < 5; i++) begin
            txn(1'b0, ld_f3[i], ld_addr[i], 32'h0, lat, rd, e, drd, dwr);
            chk($sformatf("ld%0d_rdata", i), rd, ld_exp[i]);
            chk($sformatf("ld%0d_lat", i), lat, 2);
        end

        mem[27] = 32'h13572468;
        txn(1'b0, F3_W, 32'h6C, 32'h0, lat, rd, e, drd, dwr);
        chk("lw_last_err", {31'h0, e}, 32'h0);
        chk("lw_last_rdata", rd, 32'h13572468);

        mem[1] = 32'h11223344;
        txn(1'b1, F3_B, 32'h05, 32'h000000AB, lat, rd, e, drd, dwr);
        chk("sb_lat", lat, 3);
        chk("sb_mem", mem[1], 32'h1122AB44);
        chk("sb_rd_cycles", drd, 1);
        chk("sb_wr_cycles", dwr, 1);
        chk("sb_err", {31'h0, e}, 32'h0);

        txn(1'b1, F3_H, 32'h06, 32'h0000CAFE, lat, rd, e, drd, dwr);
        chk("sh_lat", lat, 3);
        chk("sh_mem", mem[1], 32'hCAFEAB44);

        for (int i = 0; i < 4; i++) begin
            txn(er_st[i], er_f3[i], er_addr[i], 32'h12345678, lat, rd, e, drd, dwr);
            chk($sformatf("err%0d_err", i), {31'h0, e}, 32'h1);
            chk($sformatf("err%0d_rdata", i), rd, 32'h0);
            chk($sformatf("err%0d_lat", i), lat, 1);
            chk($sformatf("err%0d_enables", i), drd + dwr, 0);
        end

        // Back-pressure: response held while a second request is presented.
        @(negedge clk);
        wr0 = wr_cnt;
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = F3_W;
        bus.req_addr     = 32'h08;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid    = 1'b1;
            bus.req_is_store = 1'b1;
            bus.req_funct3   = F3_W;
            bus.req_addr     = 32'h00;
            bus.req_wdata    = 32'h55;
            chk($sformatf("bp%0d_valid", i), {31'h0, bus.resp_valid}, 32'h1);
            chk($sformatf("bp%0d_rdata", i), bus.resp_rdata, 32'hDEADBEEF);
            chk($sformatf("bp%0d_req_ready", i), {31'h0, bus.req_ready}, 32'h0);
        end
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        chk("bp_rel_req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("bp_rel_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("bp_ignored_mem", mem[0], 32'h0);
        chk("bp_ignored_wr", wr_cnt - wr0, 0);

        // Reset lands on the RMW write cycle; memory must keep the old word.
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_funct3   = F3_B;
        bus.req_addr     = 32'h04;
        bus.req_wdata    = 32'h77;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rmw_wr_active", {31'h0, bus.mem_write_en}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mid_mem", mem[1], 32'hCAFEAB44);
        chk("rst_mid_req_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_mid_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_mid_wr_en", {31'h0, bus.mem_write_en}, 32'h0);

        chk("never_both_en", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
